// File: rtl/syscon_pkg.sv
// -----------------------------------------------------------------------------
// syscon_pkg
// Shared types and defaults for the system clock/reset consumer blocks.
//   rst_seq_state_e : state encoding of the reset release sequencer
//   RST_SEQ_*       : default parameter values for rst_sequencer
//   cnt_width()     : bits needed to hold a counter's maximum value (min 1)
// -----------------------------------------------------------------------------
package syscon_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_GAP  = 2'd1,
    S_RUN  = 2'd2,
    S_SOFT = 2'd3
  } rst_seq_state_e;

  localparam int RST_SEQ_N_RST       = 4;
  localparam int RST_SEQ_SYNC_STAGES = 2;
  localparam int RST_SEQ_GAP_CYCLES  = 8;
  localparam int RST_SEQ_SOFT_CYCLES = 16;
  localparam int RST_SEQ_CNT_W       = 8;

  // Width of a counter that must reach max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    if (max_val <= 1) begin
      w = 1;
    end else begin
      w = $clog2(max_val + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// -----------------------------------------------------------------------------
// rst_sync
// Reset synchronizer: assertion passes through asynchronously, deassertion is
// aligned to clk_i after SYNC_STAGES rising edges with rst_i low.
//   clk_i  : clock the reset is synchronized to
//   rst_i  : asynchronous active-high reset
//   srst_o : synchronized active-high reset
// -----------------------------------------------------------------------------
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic srst_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift zeros in once rst_i is released; rst_i refills the chain with ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign srst_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
// Releases N_RST subsystem resets one at a time, GAP_CYCLES apart, after the
// platform reset is removed; reports readiness and re-runs the sequence on a
// software reset request.
//   clk_i          : platform clock
//   rst_i          : platform reset, asynchronous, active-high
//   soft_rst_req_i : software reset request (level, sampled on clk_i)
//   rst_o          : sequenced active-high resets, index 0 released first
//   ready_o        : all resets released, platform running
//   soft_rst_cnt_o : accepted soft resets, saturating
// -----------------------------------------------------------------------------
module rst_sequencer
  import syscon_pkg::*;
#(
  parameter int N_RST       = RST_SEQ_N_RST,
  parameter int SYNC_STAGES = RST_SEQ_SYNC_STAGES,
  parameter int GAP_CYCLES  = RST_SEQ_GAP_CYCLES,
  parameter int SOFT_CYCLES = RST_SEQ_SOFT_CYCLES,
  parameter int CNT_W       = RST_SEQ_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             soft_rst_req_i,
  output logic [N_RST-1:0] rst_o,
  output logic             ready_o,
  output logic [CNT_W-1:0] soft_rst_cnt_o
);

  // gcnt is shared between the gap and soft-hold phases.
  localparam int GCNT_MAX = ((GAP_CYCLES > SOFT_CYCLES) ? GAP_CYCLES : SOFT_CYCLES) - 1;
  localparam int GCNT_W   = cnt_width(GCNT_MAX);
  localparam int IDX_W    = cnt_width(N_RST - 1);

  localparam logic [GCNT_W-1:0] GCNT_ZERO = GCNT_W'(0);
  localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1);
  localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'(GAP_CYCLES - 1);
  localparam logic [GCNT_W-1:0] SOFT_LAST = GCNT_W'(SOFT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_RST - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [N_RST-1:0]  RST_ALL   = {N_RST{1'b1}};
  localparam logic [N_RST-1:0]  RST_NONE  = {N_RST{1'b0}};
  localparam logic [N_RST-1:0]  RST_BIT0  = N_RST'(1);

  logic           srst_s;
  rst_seq_state_e state_q, state_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_RST-1:0]  rst_q, rst_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .srst_o(srst_s)
  );

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_HOLD;
      gcnt_q  <= GCNT_ZERO;
      idx_q   <= IDX_ZERO;
      rst_q   <= RST_ALL;
      ready_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = 1'b0;
    cnt_d   = cnt_q;

    if (srst_s) begin
      state_d = S_HOLD;
      gcnt_d  = GCNT_ZERO;
      idx_d   = IDX_ZERO;
      rst_d   = RST_ALL;
    end else begin
      case (state_q)
        // S_HOLD only exists straight after reset, so gcnt/idx are already
        // zero and the exit edge counts as the first gap cycle.
        S_HOLD, S_GAP: begin
          rst_d = rst_q;
          if (gcnt_q == GAP_LAST) begin
            rst_d  = rst_q & ~(RST_BIT0 << idx_q);
            gcnt_d = GCNT_ZERO;
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              state_d = S_GAP;
            end
          end else begin
            gcnt_d  = gcnt_q + GCNT_ONE;
            state_d = S_GAP;
          end
        end
        // A request is accepted only once ready_o is visible, so a held
        // request still shows one cycle of ready before re-triggering.
        S_RUN: begin
          if (soft_rst_req_i && ready_q) begin
            rst_d   = RST_ALL;
            ready_d = 1'b0;
            gcnt_d  = GCNT_ZERO;
            state_d = S_SOFT;
            if (cnt_q != CNT_SAT) begin
              cnt_d = cnt_q + CNT_ONE;
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            rst_d   = RST_NONE;
            ready_d = 1'b1;
          end
        end
        S_SOFT: begin
          rst_d = RST_ALL;
          if (gcnt_q == SOFT_LAST) begin
            gcnt_d  = GCNT_ZERO;
            idx_d   = IDX_ZERO;
            state_d = S_GAP;
          end else begin
            gcnt_d = gcnt_q + GCNT_ONE;
          end
        end
        default: begin
          state_d = S_HOLD;
          gcnt_d  = GCNT_ZERO;
          idx_d   = IDX_ZERO;
          rst_d   = RST_ALL;
        end
      endcase
    end
  end

  assign rst_o          = rst_q;
  assign ready_o        = ready_q;
  assign soft_rst_cnt_o = cnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rst_sequencer
// Scoreboard bench for rst_sequencer. Three instances: defaults, CNT_W=2 for
// counter saturation, and the N_RST=1/GAP_CYCLES=1 corner. The stimulus
// process pushes one expected output set per clock cycle; the monitor pops
// and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_rst_sequencer;

  typedef struct {
    int         sel;
    logic [3:0] r;
    logic       rdy;
    logic [7:0] c;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;

  logic [3:0] rst_o0;
  logic       ready0;
  logic [7:0] cnt0;
  logic [3:0] rst_o1;
  logic       ready1;
  logic [1:0] cnt1;
  logic [0:0] rst_o2;
  logic       ready2;
  logic [7:0] cnt2;

  always #5 clk = ~clk;

  rst_sequencer dut0 (
    .clk_i(clk), .rst_i(rst0), .soft_rst_req_i(req0),
    .rst_o(rst_o0), .ready_o(ready0), .soft_rst_cnt_o(cnt0)
  );

  rst_sequencer #(.CNT_W(2)) dut1 (
    .clk_i(clk), .rst_i(rst1), .soft_rst_req_i(req1),
    .rst_o(rst_o1), .ready_o(ready1), .soft_rst_cnt_o(cnt1)
  );

  rst_sequencer #(.N_RST(1), .GAP_CYCLES(1), .SYNC_STAGES(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .soft_rst_req_i(req2),
    .rst_o(rst_o2), .ready_o(ready2), .soft_rst_cnt_o(cnt2)
  );

  // Expected {ready, rst[3:0]} k edges after E1 (first edge with rst_i low).
  function automatic logic [4:0] po_exp(input int k);
    logic [4:0] v;
    v[4] = (k >= 35);
    for (int i = 0; i < 4; i++) v[i] = (k < 10 + 8 * i);
    return v;
  endfunction

  // Expected {ready, rst[3:0]} k edges after the accepted soft request edge.
  function automatic logic [4:0] sr_exp(input int k);
    logic [4:0] v;
    v[4] = (k >= 49);
    for (int i = 0; i < 4; i++) v[i] = (k < 24 + 8 * i);
    return v;
  endfunction

  task automatic push(input int sel, input logic [3:0] r, input logic rdy,
                      input logic [7:0] c, input string tag);
    exp_t e;
    e.sel = sel; e.r = r; e.rdy = rdy; e.c = c; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic cyc(input int sel, input logic [3:0] r, input logic rdy,
                     input logic [7:0] c, input string tag);
    @(posedge clk);
    #1;
    push(sel, r, rdy, c, tag);
  endtask

  task automatic set_rst(input int sel, input logic v);
    case (sel)
      0: rst0 = v;
      1: rst1 = v;
      default: rst2 = v;
    endcase
  endtask

  task automatic set_req(input int sel, input logic v);
    case (sel)
      0: req0 = v;
      1: req1 = v;
      default: req2 = v;
    endcase
  endtask

  task automatic power_on(input int sel);
    logic [4:0] e;
    set_rst(sel, 1'b1);
    repeat (2) cyc(sel, 4'hF, 1'b0, 8'd0, "reset");
    set_rst(sel, 1'b0);
    for (int k = 1; k <= 36; k++) begin
      e = po_exp(k);
      cyc(sel, e[3:0], e[4], 8'd0, "power_on");
    end
  endtask

  // Soft request pulse from S_RUN, then the restart timeline up to stop_k.
  // With noise set, extra requests land in S_SOFT (k=5) and S_GAP (k=26).
  task automatic soft_run(input int sel, input logic [7:0] cnt, input bit noise,
                          input int stop_k);
    logic [4:0] e;
    set_req(sel, 1'b1);
    cyc(sel, 4'hF, 1'b0, cnt, "soft_req");
    set_req(sel, 1'b0);
    for (int k = 1; k <= stop_k; k++) begin
      set_req(sel, noise && (k == 5 || k == 26));
      e = sr_exp(k);
      cyc(sel, e[3:0], e[4], cnt, noise ? "soft_ignored" : "soft_seq");
    end
    set_req(sel, 1'b0);
  endtask

  // Monitor: compare the oldest expectation against the selected instance.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] ar;
    logic       ardy;
    logic [7:0] ac;
    if (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0: begin ar = rst_o0; ardy = ready0; ac = cnt0; end
        1: begin ar = rst_o1; ardy = ready1; ac = {6'd0, cnt1}; end
        default: begin ar = {3'd0, rst_o2}; ardy = ready2; ac = cnt2; end
      endcase
      n_chk = n_chk + 1;
      if (ar === e.r && ardy === e.rdy && ac === e.c) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL %s dut%0d t=%0t: got rst=%b ready=%b cnt=%0d, want rst=%b ready=%b cnt=%0d",
                 e.tag, e.sel, $time, ar, ardy, ac, e.r, e.rdy, e.c);
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [4:0] e;

    // Defaults: power-on, soft reset, ignored requests, mid-sequence rst_i.
    power_on(0);
    soft_run(0, 8'd1, 1'b0, 50);
    soft_run(0, 8'd2, 1'b1, 50);
    soft_run(0, 8'd3, 1'b0, 33);
    @(posedge clk);
    #1;
    rst0 = 1'b1;
    #1;
    push(0, 4'hF, 1'b0, 8'd0, "async_rst");
    cyc(0, 4'hF, 1'b0, 8'd0, "async_hold");
    rst0 = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      e = po_exp(k);
      cyc(0, e[3:0], e[4], 8'd0, "restart");
    end

    // CNT_W=2: counter saturates at 3.
    power_on(1);
    soft_run(1, 8'd1, 1'b0, 50);
    soft_run(1, 8'd2, 1'b0, 50);
    soft_run(1, 8'd3, 1'b0, 50);
    soft_run(1, 8'd3, 1'b0, 50);
    soft_run(1, 8'd3, 1'b0, 50);

    // N_RST=1, GAP_CYCLES=1: release at E3, ready at E4.
    set_rst(2, 1'b1);
    repeat (2) cyc(2, 4'h1, 1'b0, 8'd0, "corner_reset");
    set_rst(2, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc(2, (k < 3) ? 4'h1 : 4'h0, (k >= 4), 8'd0, "corner");
    end

    repeat (2) @(negedge clk);
    n_chk = n_chk + 1;
    if (q.size() == 0) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
